mem_cmd_responder: RTL and testbench
====================================

MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the number of implemented address bits.
REQ-003 SHALL have parameter DEPTH, default 256 (2**ADDR_W), meaning the number of words in the memory.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: memCmd  input  2  command code: 00 NOP, 01 WRITE, 10 READ, 11 CLEAR.
REQ-007 SHALL have port: memAddrIn  input  64  word address from the IO controller.
REQ-008 SHALL have port: ioDataIn  input  32  write data from the IO controller.
REQ-009 SHALL have port: ioCmdDoneIn  input  1  request: initiator has finished entering command, address and data.
REQ-010 SHALL have port: memCmdDoneOut  output  1  high = ready/complete; low = busy.
REQ-011 SHALL have port: memDataOut  output  32  read result.
REQ-012 SHALL have port: addrErr  output  1  last command addressed beyond DEPTH.

Function
REQ-013 SHALL implement a four-phase handshake with FSM states IDLE, EXEC, CLR and DONE.
REQ-014 IDLE: when ioCmdDoneIn=1 and memCmd!=NOP, SHALL latch memCmd, memAddrIn and ioDataIn, drive memCmdDoneOut to 0 at the same edge, and clear addrErr.
REQ-015 IDLE: WRITE or READ SHALL go to EXEC, and CLEAR SHALL go to CLR.
REQ-016 IDLE: NOP with ioCmdDoneIn=1 SHALL be ignored; the FSM stays in IDLE and memCmdDoneOut stays 1.
REQ-017 SHALL treat the latched values as the only operands; changes on memCmd, memAddrIn or ioDataIn after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-018 Address range: the address SHALL be out of range when any of memAddrIn[63:ADDR_W] is nonzero or the address is >= DEPTH.
REQ-019 Out-of-range WRITE or READ: SHALL leave memory untouched, set addrErr=1, and load memDataOut with 0 on READ.
REQ-020 EXEC (one cycle): WRITE SHALL store the data word at the address; READ SHALL load memDataOut with mem[address]. The FSM then goes to DONE.
REQ-021 Write/read latency: accept at edge N; memCmdDoneOut=0 after edge N; the operation executes at edge N+1; memCmdDoneOut=1 after edge N+1.
REQ-022 CLR: a counter running 0..DEPTH-1 SHALL write 0 to one word per cycle, then go to DONE at the edge after the write of the last word.
REQ-023 CLEAR latency: memCmdDoneOut SHALL return to 1 DEPTH edges after acceptance.
REQ-024 CLEAR SHALL ignore the address and SHALL NOT change memDataOut.
REQ-025 DONE: memCmdDoneOut=1; the FSM SHALL wait for ioCmdDoneIn=0 and then go to IDLE.
REQ-026 DONE: while ioCmdDoneIn stays 1, no new command SHALL be accepted.
REQ-027 memDataOut SHALL hold its value until the next READ completes.
REQ-028 addrErr SHALL hold its value until the next command is accepted.
REQ-029 Read-after-write SHALL return the newly written data; the memory SHALL have no bypass hazards, since each operation completes before the next is accepted.

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to IDLE, memCmdDoneOut=1, memDataOut=0, addrErr=0, and the clear counter and latched operands SHALL become 0.
REQ-031 Memory contents SHALL NOT be initialised by reset; only CLEAR zeroes the memory.
REQ-032 Reset during EXEC SHALL abort the operation with no write.
REQ-033 Reset during CLR SHALL abort the clear; already-cleared words stay 0 and the rest keep their old values.
REQ-034 rst SHALL take priority over a simultaneous ioCmdDoneIn=1.

Structure
REQ-035 Package mem_ctrl_pkg SHALL hold the command enum (NOP, WRITE, READ, CLEAR), the DATA_W, ADDR_W and DEPTH defaults, and the FSM state typedef.
REQ-036 The memory SHALL be a sub-module mem_array: single-port, synchronous write, registered read, DEPTH x DATA_W, with no reset.
REQ-037 The FSM, operand latches, clear counter and range check SHALL be in mem_cmd_responder.

Verification
REQ-038 Scenario: WRITE addr 0x0F data 0xDEADBEEF, then READ addr 0x0F -> memDataOut=0xDEADBEEF; memCmdDoneOut low exactly 1 cycle per command; addrErr=0.
REQ-039 Scenario: READ addr 0x100 (bit 8 set) -> addrErr=1, memDataOut=0; a subsequent WRITE 0x00 -> addrErr cleared at accept.
REQ-040 Scenario: write 0xA5A5A5A5 to addrs 0x00 and 0xFF, then CLEAR -> memCmdDoneOut low for 256 cycles; READ of 0x00 and 0xFF -> 0.
REQ-041 Scenario: hold ioCmdDoneIn=1 through DONE with memCmd changed to WRITE -> no second write occurs; the next command is accepted only after ioCmdDoneIn=0 then 1.
REQ-042 Scenario: assert rst at cycle 100 of a CLEAR -> memCmdDoneOut=1 and FSM=IDLE next cycle; word 0x00 reads 0 and word 0xFF keeps 0xA5A5A5A5.
REQ-043 Scenario: NOP with ioCmdDoneIn=1 -> memCmdDoneOut stays 1 and memory and outputs are unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared command codes, FSM states and default geometry for the memory command responder.
package mem_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    CLEAR = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    CLR  = 2'b10,
    DONE = 2'b11
  } state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W word store: synchronous write, registered read, no reset.
// Read-during-write returns the old word; callers never depend on that case.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_cmd_responder.sv
// Four-phase command responder: WRITE/READ complete one edge after accept, CLEAR after DEPTH edges.
// memCmdDoneOut low means busy; a finished command waits for ioCmdDoneIn to drop before re-arming.
module mem_cmd_responder
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memCmd,
  input  logic [63:0]       memAddrIn,
  input  logic [DATA_W-1:0] ioDataIn,
  input  logic              ioCmdDoneIn,
  output logic              memCmdDoneOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic              addrErr
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  mem_cmd_e          cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oor_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              done_q;
  logic              addr_err_q;
  logic [DATA_W-1:0] dout_q;

  mem_cmd_e          cmd_in;
  logic              accept;
  logic              addr_hi_nz;
  logic              addr_oor;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd_in     = mem_cmd_e'(memCmd);
  assign accept     = (state_q == IDLE) && ioCmdDoneIn && (cmd_in != NOP);
  assign addr_hi_nz = |memAddrIn[63:ADDR_W];

  generate
    if (DEPTH < (2 ** ADDR_W)) begin : g_partial_depth
      assign addr_oor = addr_hi_nz || (32'(memAddrIn[ADDR_W-1:0]) >= 32'(DEPTH));
    end else begin : g_full_depth
      assign addr_oor = addr_hi_nz;
    end
  endgenerate

  // In IDLE the live address feeds the read port so the word is ready by EXEC.
  // Writes are masked by rst so a reset edge never commits a partial operation.
  always_comb begin
    mem_addr  = memAddrIn[ADDR_W-1:0];
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state_q)
      EXEC: begin
        mem_addr = addr_q;
        mem_we   = (cmd_q == WRITE) && !oor_q && !rst;
      end
      CLR: begin
        mem_addr  = clr_cnt_q;
        mem_we    = !rst;
        mem_wdata = '0;
      end
      default: ;
    endcase
  end

  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      clr_cnt_q  <= '0;
      done_q     <= 1'b1;
      addr_err_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q      <= cmd_in;
            addr_q     <= memAddrIn[ADDR_W-1:0];
            wdata_q    <= ioDataIn;
            oor_q      <= addr_oor;
            clr_cnt_q  <= '0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            state_q    <= (cmd_in == CLEAR) ? CLR : EXEC;
          end
        end
        EXEC: begin
          if (oor_q) addr_err_q <= 1'b1;
          if (cmd_q == READ) dout_q <= oor_q ? '0 : mem_rdata;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        CLR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (!ioCmdDoneIn) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memCmdDoneOut = done_q;
  assign memDataOut    = dout_q;
  assign addrErr       = addr_err_q;
endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench: a vector table of full handshakes plus hand-written reset/hold/NOP sequences.
module tb_mem_cmd_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  memCmd;
  logic [63:0] memAddrIn;
  logic [31:0] ioDataIn;
  logic        ioCmdDoneIn;
  logic        memCmdDoneOut;
  logic [31:0] memDataOut;
  logic        addrErr;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [1:0] C_NOP = 2'b00, C_WR = 2'b01, C_RD = 2'b10, C_CLR = 2'b11;

  always #5 clk = ~clk;

  mem_cmd_responder dut (
    .clk          (clk),
    .rst          (rst),
    .memCmd       (memCmd),
    .memAddrIn    (memAddrIn),
    .ioDataIn     (ioDataIn),
    .ioCmdDoneIn  (ioCmdDoneIn),
    .memCmdDoneOut(memCmdDoneOut),
    .memDataOut   (memDataOut),
    .addrErr      (addrErr)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [31:0] data;
    int          exp_low;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full handshake; operands are scrambled right after accept to prove they were latched.
  task automatic do_cmd(input logic [1:0] c, input logic [63:0] a, input logic [31:0] d,
                        output int low);
    @(negedge clk);
    memCmd = c; memAddrIn = a; ioDataIn = d; ioCmdDoneIn = 1'b1;
    low = 0;
    @(negedge clk);
    memCmd = ~c; memAddrIn = ~a; ioDataIn = ~d;
    while (memCmdDoneOut == 1'b0 && low < 400) begin
      low++;
      @(negedge clk);
    end
    ioCmdDoneIn = 1'b0;
    memCmd = C_NOP;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    vecs[0]  = '{C_WR,  64'h0F,                  32'hDEADBEEF, 1,   32'h0,        1'b0};
    vecs[1]  = '{C_RD,  64'h0F,                  32'h0,        1,   32'hDEADBEEF, 1'b0};
    vecs[2]  = '{C_RD,  64'h100,                 32'h0,        1,   32'h0,        1'b1};
    vecs[3]  = '{C_WR,  64'h00,                  32'hA5A5A5A5, 1,   32'h0,        1'b0};
    vecs[4]  = '{C_WR,  64'hFF,                  32'hA5A5A5A5, 1,   32'h0,        1'b0};
    vecs[5]  = '{C_RD,  64'hFF,                  32'h0,        1,   32'hA5A5A5A5, 1'b0};
    vecs[6]  = '{C_WR,  64'h10,                  32'h11111111, 1,   32'hA5A5A5A5, 1'b0};
    vecs[7]  = '{C_WR,  64'h8000_0000_0000_0010, 32'h22222222, 1,   32'hA5A5A5A5, 1'b1};
    vecs[8]  = '{C_RD,  64'h10,                  32'h0,        1,   32'h11111111, 1'b0};
    vecs[9]  = '{C_CLR, 64'h10,                  32'h33333333, 256, 32'h11111111, 1'b0};
    vecs[10] = '{C_RD,  64'h00,                  32'h0,        1,   32'h0,        1'b0};
    vecs[11] = '{C_RD,  64'hFF,                  32'h0,        1,   32'h0,        1'b0};
    vecs[12] = '{C_RD,  64'h0F,                  32'h0,        1,   32'h0,        1'b0};
    vecs[13] = '{C_RD,  64'h10,                  32'h0,        1,   32'h0,        1'b0};

    rst = 1'b1; memCmd = C_NOP; memAddrIn = '0; ioDataIn = '0; ioCmdDoneIn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset done", 64'(memCmdDoneOut), 64'd1);
    chk("reset dout", 64'(memDataOut), 64'd0);
    chk("reset err", 64'(addrErr), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].data, low);
      chk($sformatf("vec%0d low_cycles", i), 64'(low), 64'(vecs[i].exp_low));
      chk($sformatf("vec%0d dout", i), 64'(memDataOut), 64'(vecs[i].exp_dout));
      chk($sformatf("vec%0d err", i), 64'(addrErr), 64'(vecs[i].exp_err));
    end

    // Held ioCmdDoneIn in DONE with a fresh WRITE presented must not re-trigger.
    @(negedge clk);
    memCmd = C_WR; memAddrIn = 64'h20; ioDataIn = 32'h55; ioCmdDoneIn = 1'b1;
    @(negedge clk);
    chk("hold accept busy", 64'(memCmdDoneOut), 64'd0);
    @(negedge clk);
    chk("hold done", 64'(memCmdDoneOut), 64'd1);
    ioDataIn = 32'h66;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold no_accept%0d", k), 64'(memCmdDoneOut), 64'd1);
    end
    ioCmdDoneIn = 1'b0; memCmd = C_NOP;
    @(negedge clk);
    do_cmd(C_RD, 64'h20, 32'h0, low);
    chk("hold reread low", 64'(low), 64'd1);
    chk("hold reread dout", 64'(memDataOut), 64'h55);

    // NOP with request high changes nothing.
    @(negedge clk);
    memCmd = C_NOP; memAddrIn = 64'h20; ioDataIn = 32'hBAD; ioCmdDoneIn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("nop done%0d", k), 64'(memCmdDoneOut), 64'd1);
    end
    chk("nop dout", 64'(memDataOut), 64'h55);
    chk("nop err", 64'(addrErr), 64'd0);
    ioCmdDoneIn = 1'b0;

    // Reset wins over a simultaneous WRITE request in IDLE.
    @(negedge clk);
    rst = 1'b1; memCmd = C_WR; memAddrIn = 64'h20; ioDataIn = 32'h77; ioCmdDoneIn = 1'b1;
    @(negedge clk);
    rst = 1'b0; ioCmdDoneIn = 1'b0; memCmd = C_NOP;
    chk("rst_prio done", 64'(memCmdDoneOut), 64'd1);
    chk("rst_prio dout", 64'(memDataOut), 64'd0);

    // Reset on the EXEC edge aborts the write.
    @(negedge clk);
    memCmd = C_WR; memAddrIn = 64'h20; ioDataIn = 32'h99; ioCmdDoneIn = 1'b1;
    @(negedge clk);
    rst = 1'b1; ioCmdDoneIn = 1'b0; memCmd = C_NOP;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec done", 64'(memCmdDoneOut), 64'd1);
    do_cmd(C_RD, 64'h20, 32'h0, low);
    chk("rst_exec reread", 64'(memDataOut), 64'h55);

    // Reset around cycle 100 of a CLEAR: low words cleared, word 0xFF untouched.
    do_cmd(C_WR, 64'h00, 32'hA5A5A5A5, low);
    do_cmd(C_WR, 64'hFF, 32'hA5A5A5A5, low);
    @(negedge clk);
    memCmd = C_CLR; memAddrIn = 64'h0; ioCmdDoneIn = 1'b1;
    @(negedge clk);
    chk("rst_clr busy", 64'(memCmdDoneOut), 64'd0);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clr done", 64'(memCmdDoneOut), 64'd1);
    chk("rst_clr err", 64'(addrErr), 64'd0);
    rst = 1'b0; ioCmdDoneIn = 1'b0; memCmd = C_NOP;
    do_cmd(C_RD, 64'h00, 32'h0, low);
    chk("rst_clr idle_accept low", 64'(low), 64'd1);
    chk("rst_clr word00", 64'(memDataOut), 64'h0);
    do_cmd(C_RD, 64'hFF, 32'h0, low);
    chk("rst_clr wordFF", 64'(memDataOut), 64'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
